// File: rtl/imm_sel_pipe_if.sv
// Request/result bundle for imm_sel_pipe: valid/ready in, valid/ready out.
// The slave modport is the selector's view; master is the producer/consumer side.
interface imm_sel_pipe_if #(
  parameter int DATA_W = 32,
  parameter int SRC_W  = 16,
  parameter int N_SRC  = 2
);
  localparam int SEL_W = $clog2(N_SRC);

  logic                   in_valid;
  logic                   in_ready;
  logic [N_SRC*SRC_W-1:0] src;
  logic [SEL_W-1:0]       sel;
  logic [1:0]             mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      imm;
  logic                   err;

  modport slave  (input  in_valid, src, sel, mode, out_ready,
                  output in_ready, out_valid, imm, err);
  modport master (output in_valid, src, sel, mode, out_ready,
                  input  in_ready, out_valid, imm, err);
endinterface

// File: rtl/imm_sel_pipe.sv
// Registered N-way immediate selector/extender with valid/ready output.
// IMM_SEL_PIPE_SKID_EN adds a skid register and a registered in_ready.
module imm_sel_pipe #(
  parameter int DATA_W = 32,
  parameter int SRC_W  = 16,
  parameter int N_SRC  = 2,
  parameter int SEL_W  = $clog2(N_SRC)
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_sel_pipe_if.slave  bus
);

  logic [SRC_W-1:0]  w_field;
  logic              w_err;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_imm;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_drain;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_imm;
  logic              r_err;

  // An unmatched select leaves w_err set, which forces the result to zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_field = '0;
    w_err   = 1'b1;
    for (int k = 0; k < N_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_field = bus.src[k*SRC_W +: SRC_W];
        w_err   = 1'b0;
      end
    end
  end

  assign w_sext = {{(DATA_W-SRC_W){w_field[SRC_W-1]}}, w_field};

  always_comb begin
    w_imm = '0;
    case (bus.mode)
      2'b00: w_imm = {{(DATA_W-SRC_W){1'b0}}, w_field};
      2'b01: w_imm = w_sext;
      2'b10: w_imm = {w_sext[DATA_W-3:0], 2'b00};
      2'b11: w_imm = {w_field, {(DATA_W-SRC_W){1'b0}}};
      default: w_imm = '0;
    endcase
    if (w_err) w_imm = '0;
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_drain  = r_out_valid && bus.out_ready;

`ifdef IMM_SEL_PIPE_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_skid_imm;
  logic              r_skid_err;

  assign w_in_ready = r_in_ready;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_err       <= 1'b0;
      r_skid_imm  <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          r_imm       <= w_imm;
          r_err       <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= S_FULL;
        end
        S_FULL: begin
          if (w_accept && w_drain) begin
            r_imm <= w_imm;
            r_err <= w_err;
          end else if (w_accept) begin
            r_skid_imm <= w_imm;
            r_skid_err <= w_err;
            r_in_ready <= 1'b0;
            r_state    <= S_SKID;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        // Draining the older entry promotes the skid entry, preserving order.
        S_SKID: if (w_drain) begin
          r_imm      <= r_skid_imm;
          r_err      <= r_skid_err;
          r_in_ready <= 1'b1;
          r_state    <= S_FULL;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end
`else
  // Without a skid slot the register may reload only when it is being emptied.
  assign w_in_ready = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_imm       <= w_imm;
      r_err       <= w_err;
      r_out_valid <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.imm       = r_imm;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_imm_sel_pipe.sv
// Directed bench for imm_sel_pipe: a table of selection/mode vectors plus
// hand-written backpressure, out-of-range select and mid-operation reset sequences.
module tb_imm_sel_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  imm_sel_pipe_if #(.DATA_W(32), .SRC_W(16), .N_SRC(2)) bus2 ();
  imm_sel_pipe_if #(.DATA_W(32), .SRC_W(16), .N_SRC(3)) bus3 ();

  imm_sel_pipe #(.DATA_W(32), .SRC_W(16), .N_SRC(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  imm_sel_pipe #(.DATA_W(32), .SRC_W(16), .N_SRC(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct {
    logic [15:0] src0;
    logic [15:0] src1;
    logic        sel;
    logic [1:0]  mode;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h0004, 16'h0001, 1'b0, 2'b00, 32'h0000_0004};
    vecs[1]  = '{16'h0004, 16'h0001, 1'b1, 2'b00, 32'h0000_0001};
    vecs[2]  = '{16'h0004, 16'h0001, 1'b0, 2'b00, 32'h0000_0004};
    vecs[3]  = '{16'h0004, 16'h8001, 1'b1, 2'b00, 32'h0000_8001};
    vecs[4]  = '{16'h0004, 16'h8001, 1'b1, 2'b01, 32'hFFFF_8001};
    vecs[5]  = '{16'h0004, 16'h8001, 1'b1, 2'b10, 32'hFFFE_0004};
    vecs[6]  = '{16'h0004, 16'h8001, 1'b1, 2'b11, 32'h8001_0000};
    vecs[7]  = '{16'h0004, 16'h8001, 1'b0, 2'b01, 32'h0000_0004};
    vecs[8]  = '{16'h0004, 16'h8001, 1'b0, 2'b10, 32'h0000_0010};
    vecs[9]  = '{16'h0004, 16'h8001, 1'b0, 2'b11, 32'h0004_0000};
    vecs[10] = '{16'h0004, 16'h7FFF, 1'b1, 2'b01, 32'h0000_7FFF};
    vecs[11] = '{16'h0004, 16'h7FFF, 1'b1, 2'b10, 32'h0001_FFFC};

    rst_n          = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.src       = '0;
    bus2.sel       = '0;
    bus2.mode      = 2'b00;
    bus2.out_ready = 1'b1;
    bus3.in_valid  = 1'b0;
    bus3.src       = '0;
    bus3.sel       = '0;
    bus3.mode      = 2'b00;
    bus3.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    checkb("rst out_valid", bus2.out_valid, 1'b0);
    check ("rst imm",       bus2.imm,       32'h0);
    checkb("rst err",       bus2.err,       1'b0);
    checkb("rst in_ready",  bus2.in_ready,  1'b1);
    checkb("rst3 out_valid", bus3.out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    checkb("post-rst in_ready", bus2.in_ready, 1'b1);

    // Back-to-back selection/mode vectors, one result per cycle
    for (int i = 0; i < 12; i++) begin
      bus2.src      = {vecs[i].src1, vecs[i].src0};
      bus2.sel      = vecs[i].sel;
      bus2.mode     = vecs[i].mode;
      bus2.in_valid = 1'b1;
      tick();
      checkb($sformatf("vec%0d out_valid", i), bus2.out_valid, 1'b1);
      check ($sformatf("vec%0d imm", i),       bus2.imm,       vecs[i].exp_imm);
      checkb($sformatf("vec%0d err", i),       bus2.err,       1'b0);
      checkb($sformatf("vec%0d in_ready", i),  bus2.in_ready,  1'b1);
    end
    bus2.in_valid = 1'b0;
    tick();
    checkb("drain out_valid", bus2.out_valid, 1'b0);

    // Backpressure
    bus2.sel       = 1'b1;
    bus2.mode      = 2'b00;
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.src       = {16'h0001, 16'h0000};
    #1;
    checkb("bp first in_ready", bus2.in_ready, 1'b1);
    tick();
    check ("bp hold imm1", bus2.imm, 32'h1);
`ifdef IMM_SEL_PIPE_SKID_EN
    bus2.src = {16'h0002, 16'h0000};
    tick();
    checkb("bp skid in_ready", bus2.in_ready, 1'b0);
    checkb("bp skid out_valid", bus2.out_valid, 1'b1);
    check ("bp skid imm stable", bus2.imm, 32'h1);
    bus2.src = {16'h0003, 16'h0000};
    tick();
    checkb("bp third refused", bus2.in_ready, 1'b0);
    check ("bp still imm1", bus2.imm, 32'h1);
    bus2.out_ready = 1'b1;
    tick();
    checkb("bp out2 valid", bus2.out_valid, 1'b1);
    check ("bp out2 imm", bus2.imm, 32'h2);
    checkb("bp out2 in_ready", bus2.in_ready, 1'b1);
    tick();
    checkb("bp out3 valid", bus2.out_valid, 1'b1);
    check ("bp out3 imm", bus2.imm, 32'h3);
    bus2.in_valid = 1'b0;
    tick();
    checkb("bp no repeat", bus2.out_valid, 1'b0);
`else
    checkb("bp comb in_ready low", bus2.in_ready, 1'b0);
    bus2.src = {16'h0002, 16'h0000};
    tick();
    check ("bp imm stable", bus2.imm, 32'h1);
    checkb("bp out_valid", bus2.out_valid, 1'b1);
    bus2.out_ready = 1'b1;
    #1;
    checkb("bp comb in_ready high", bus2.in_ready, 1'b1);
    tick();
    checkb("bp replace valid", bus2.out_valid, 1'b1);
    check ("bp replace imm", bus2.imm, 32'h2);
    bus2.in_valid = 1'b0;
    tick();
    checkb("bp no repeat", bus2.out_valid, 1'b0);
`endif

    // Out-of-range select on the three-field instance
    bus3.src      = {16'hFFFF, 16'h1234, 16'h8000};
    bus3.sel      = 2'd3;
    bus3.mode     = 2'b01;
    bus3.in_valid = 1'b1;
    tick();
    checkb("oor out_valid", bus3.out_valid, 1'b1);
    checkb("oor err", bus3.err, 1'b1);
    check ("oor imm", bus3.imm, 32'h0);
    bus3.sel = 2'd0;
    tick();
    checkb("sel0 err", bus3.err, 1'b0);
    check ("sel0 imm", bus3.imm, 32'hFFFF_8000);
    bus3.sel  = 2'd2;
    bus3.mode = 2'b00;
    tick();
    check ("sel2 imm", bus3.imm, 32'h0000_FFFF);
    checkb("sel2 err", bus3.err, 1'b0);
    bus3.in_valid = 1'b0;
    tick();
    checkb("oor drain", bus3.out_valid, 1'b0);

    // Reset while data is held
    bus2.out_ready = 1'b0;
    bus2.in_valid  = 1'b1;
    bus2.src       = {16'h0055, 16'h0000};
    tick();
    bus2.src = {16'h0066, 16'h0000};
    tick();
    checkb("pre-rst in_ready", bus2.in_ready, 1'b0);
    rst_n         = 1'b0;
    bus2.in_valid = 1'b0;
    tick();
    checkb("midrst out_valid", bus2.out_valid, 1'b0);
    check ("midrst imm", bus2.imm, 32'h0);
    checkb("midrst in_ready", bus2.in_ready, 1'b1);
    rst_n          = 1'b1;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkb($sformatf("no stale valid %0d", i), bus2.out_valid, 1'b0);
      check ($sformatf("no stale imm %0d", i), bus2.imm, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
